npu_test_sequencer: RTL
=======================

# npu_test_sequencer

Parametrised AHB-Lite master that runs a regression over the NPU in test mode. For each of NUM_IMAGES stored test images it:
- selects the image index;
- starts an inference;
- polls the status register until done;
- reads the predicted class and compares it with an expected class, accumulating pass/fail counts.

It sits in the simulation/bring-up top between the bus fabric and the NPU AHB slave port, and also drives the NPU test image index. It generalises the fixed single-image AHB control master with image count, address map, poll pacing, error handling and result scoring.

## Interface
Parameters:
- NUM_IMAGES, 4: number of test images swept, index 0..NUM_IMAGES-1 (≥1).
- IDX_W, 2: width of test_img_index_o; requires 2^IDX_W ≥ NUM_IMAGES.
- CLASS_W, 5: width of the class field in the result register.
- CTRL_ADDR, 32'h0000_0000: control register; write 1 starts inference.
- STATUS_ADDR, 32'h0000_0004: status register; bit0 is done.
- RESULT_ADDR, 32'h0000_0008: result register; bits [CLASS_W-1:0] hold the class.
- POLL_GAP, 8: idle cycles between status polls (≥0).
- TIMEOUT_CYC, 1_000_000: poll watchdog limit (used only with SEQ_TIMEOUT_EN).

Ports:
- clk in 1: clock.
- resetn in 1: synchronous, active-low reset.
- start_i in 1: single-cycle pulse; begins a sweep when idle, ignored otherwise.
- exp_class_i in NUM_IMAGES*CLASS_W: expected class per image; image k occupies slice [k*CLASS_W +: CLASS_W].
- ahb_haddr_o out 32, ahb_hwrite_o out 1, ahb_hsize_o out 3, ahb_hburst_o out 3, ahb_hprot_o out 4, ahb_htrans_o out 2, ahb_hmastlock_o out 1, ahb_hwdata_o out 32: AHB-Lite master outputs.
- ahb_hready_i in 1, ahb_hresp_i in 1, ahb_hrdata_i in 32: AHB-Lite slave responses.
- test_img_index_o out IDX_W: image select to the NPU.
- busy_o out 1: high from the cycle after start_i is accepted until DONE or ERR is entered.
- done_o out 1: sticky; set on sweep completion or error, cleared on the next accepted start_i.
- err_o out 1: sticky bus error (or timeout); cleared on the next accepted start_i.
- pass_cnt_o out $clog2(NUM_IMAGES+1): number of images that matched.
- fail_cnt_o out $clog2(NUM_IMAGES+1): number of images that mismatched.
- last_class_o out CLASS_W: most recently read class.

## Operation
- Fixed bus fields:
  - hsize = 3'b010 (word), hburst = 3'b000 (SINGLE), hprot = 4'b0011, hmastlock = 0.
  - htrans = NONSEQ (2'b10) only in address-phase states, IDLE (2'b00) otherwise.
  - No transaction pipelining: a new address phase is issued only after the previous data phase completes.
- FSM states: IDLE, SET_IDX, WR_A, WR_D, POLL_A, POLL_D, GAP, RES_A, RES_D, NEXT, DONE, ERR.
- State transitions:
  - IDLE: on start_i, clear the counters, done_o and err_o, set index = 0, go to SET_IDX.
  - SET_IDX: drive test_img_index_o = index for one cycle, go to WR_A.
  - WR_A: haddr = CTRL_ADDR, hwrite = 1, NONSEQ. Advance to WR_D when hready = 1; hold otherwise.
  - WR_D: hwdata = 32'h1. Complete on hready = 1, then go to POLL_A.
  - POLL_A: read of STATUS_ADDR. POLL_D samples hrdata[0] on hready = 1. If it is 1, go to RES_A; otherwise go to GAP.
  - GAP: count POLL_GAP cycles, then return to POLL_A. With POLL_GAP = 0, go directly to POLL_A.
  - RES_A: read of RESULT_ADDR. RES_D captures last_class_o = hrdata[CLASS_W-1:0] on hready = 1.
  - On the RES_D capture, compare against the image's exp_class_i slice and increment pass_cnt_o on a match, fail_cnt_o otherwise.
  - NEXT: if index == NUM_IMAGES-1, go to DONE; else increment index and go to SET_IDX.
  - DONE: set done_o, then go to IDLE.
- Error handling:
  - hresp = 1 during any data phase: complete the two-cycle ERROR response per AHB-Lite, then enter ERR.
  - ERR sets err_o and done_o, drives htrans IDLE, does not update the counters, then returns to IDLE.
- start_i while busy_o = 1 is ignored.
- test_img_index_o holds its value during the whole per-image transaction.

## Timing
- Reset values (resetn = 0 at a rising edge): state IDLE, all AHB outputs 0 (htrans IDLE), test_img_index_o 0, busy/done/err 0, counters 0, last_class_o 0.
- Reset mid-sweep: abandon immediately and drive htrans IDLE on the next cycle. No completion of the outstanding transfer is required.
- Per-image minimum latency with zero wait states and done on the first poll: 1 (SET_IDX) + 2 (write) + 2 (poll) + 2 (result) + 1 (NEXT) = 8 cycles.
- Each additional poll adds 2 + POLL_GAP cycles; each slave wait state adds 1 cycle.
- Count update: pass_cnt_o and fail_cnt_o change in the cycle after the RES_D completion edge.
- Start latency: start_i sampled in IDLE gives busy_o = 1 one cycle later and the first NONSEQ two cycles later.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A 32-bit watchdog resets on entry to POLL_A from WR_D.
  - It counts every cycle spent in POLL_A, POLL_D and GAP.
  - On reaching TIMEOUT_CYC it forces ERR (err_o = 1) at the next data-phase completion boundary, or from GAP immediately.
- SEQ_TIMEOUT_EN undefined: no watchdog logic; polling continues indefinitely.

## Test plan
- NUM_IMAGES = 4, zero-wait slave, status done on first poll, results 3,7,1,9 with expected 3,7,1,9 -> done_o = 1, pass_cnt_o = 4, fail_cnt_o = 0, 32 cycles from first NONSEQ region, index sequence 0,1,2,3.
- Expected 3,7,2,9 (image 2 mismatches) -> pass_cnt_o = 3, fail_cnt_o = 1, last_class_o = 9.
- Status done only on the 5th poll with POLL_GAP = 8, plus 2 wait states on every data phase -> poll spacing is exactly 8 idle cycles, hwdata = 1 stable through the waits, counts correct.
- hresp = 1 on the status read of image 1 -> two-cycle ERROR honoured, err_o = 1, done_o = 1, pass_cnt_o = 1, htrans IDLE afterwards; a new start_i clears err_o.
- Reset asserted during WR_D of image 2 -> next cycle all outputs at reset values; a new start_i restarts from image 0; start_i while busy has no effect.
- With SEQ_TIMEOUT_EN, TIMEOUT_CYC = 100 and status never done -> err_o = 1 within 100 + POLL_GAP + 2 cycles of the first poll.

Source files
------------

// File: rtl/npu_test_sequencer_if.sv
// -----------------------------------------------------------------------------
// npu_test_sequencer_if
//   AHB-Lite bundle between the NPU test sequencer (master) and the NPU AHB
//   slave port.
//
//   Signals:
//     haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata
//                          master -> slave address/control/write data
//     hready, hresp, hrdata
//                          slave -> master transfer response and read data
//
//   Modports: master (sequencer side), slave (NPU / fabric side).
// -----------------------------------------------------------------------------
interface npu_test_sequencer_if;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/npu_test_sequencer.sv
// -----------------------------------------------------------------------------
// npu_test_sequencer
//   AHB-Lite master that sweeps the NPU test images: for each image it selects
//   the index, writes 1 to the control register, polls the status register
//   until bit0 is set, reads the result class and scores it against the
//   expected class. Transfers are never pipelined.
//
//   Optional feature: define SEQ_TIMEOUT_EN to add a poll watchdog that
//   forces the error exit after TIMEOUT_CYC cycles of polling.
//
//   Ports:
//     clk, resetn        clock, synchronous active-low reset
//     start_i            one-cycle pulse, starts a sweep when idle
//     exp_class_i        expected class per image, image k at [k*CLASS_W +: CLASS_W]
//     ahb                AHB-Lite master bundle (npu_test_sequencer_if.master)
//     test_img_index_o   image select to the NPU
//     busy_o             sweep in progress
//     done_o, err_o      sticky completion / error flags, cleared on start
//     pass_cnt_o         images whose class matched
//     fail_cnt_o         images whose class mismatched
//     last_class_o       most recently read class
// -----------------------------------------------------------------------------
module npu_test_sequencer #(
  parameter int unsigned NUM_IMAGES  = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned CLASS_W     = 5,
  parameter logic [31:0] CTRL_ADDR   = 32'h0000_0000,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_0004,
  parameter logic [31:0] RESULT_ADDR = 32'h0000_0008,
  parameter int unsigned POLL_GAP    = 8,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                start_i,
  input  logic [NUM_IMAGES*CLASS_W-1:0]       exp_class_i,
  npu_test_sequencer_if.master                ahb,
  output logic [IDX_W-1:0]                    test_img_index_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                err_o,
  output logic [$clog2(NUM_IMAGES+1)-1:0]     pass_cnt_o,
  output logic [$clog2(NUM_IMAGES+1)-1:0]     fail_cnt_o,
  output logic [CLASS_W-1:0]                  last_class_o
);

  localparam int unsigned CNT_W    = $clog2(NUM_IMAGES + 1);
  localparam logic [31:0] GAP_LAST = (POLL_GAP > 0) ? 32'(POLL_GAP - 1) : 32'd0;
  localparam logic [1:0]  HT_IDLE   = 2'b00;
  localparam logic [1:0]  HT_NONSEQ = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SET_IDX,
    S_WR_A,
    S_WR_D,
    S_POLL_A,
    S_POLL_D,
    S_GAP,
    S_RES_A,
    S_RES_D,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_done;
  logic               r_err;
  logic [CNT_W-1:0]   r_pass;
  logic [CNT_W-1:0]   r_fail;
  logic [CLASS_W-1:0] r_last_class;
  logic [31:0]        r_gap_cnt;

  logic [CLASS_W-1:0] w_exp_class;
  logic [CLASS_W-1:0] w_rd_class;
  logic               w_last_img;
  logic               w_tmo;
  logic               w_unused_rdata;

  // Bus outputs
  logic [31:0]        w_haddr;
  logic               w_hwrite;
  logic [1:0]         w_htrans;
  logic [31:0]        w_hwdata;
  logic               w_active;

  assign w_rd_class     = ahb.hrdata[CLASS_W-1:0];
  assign w_last_img     = (r_idx == IDX_W'(NUM_IMAGES - 1));
  assign w_unused_rdata = ^ahb.hrdata;

  // Expected class of the current image (loop avoids a variable-width multiply)
  always_comb begin
    w_exp_class = '0;
    for (int unsigned k = 0; k < NUM_IMAGES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_exp_class = exp_class_i[k*CLASS_W +: CLASS_W];
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] r_wdog;

  // Restarted when polling begins for an image; saturates once expired
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wdog <= '0;
    end else if (r_state == S_WR_D && w_next == S_POLL_A) begin
      r_wdog <= '0;
    end else if ((r_state == S_POLL_A || r_state == S_POLL_D || r_state == S_GAP) && !w_tmo) begin
      r_wdog <= r_wdog + 32'd1;
    end
  end

  assign w_tmo = (r_wdog >= 32'(TIMEOUT_CYC));
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
  assign w_tmo = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start_i) w_next = S_SET_IDX;
      S_SET_IDX: w_next = S_WR_A;
      S_WR_A:    if (ahb.hready) w_next = S_WR_D;
      S_WR_D: begin
        if (ahb.hready) w_next = ahb.hresp ? S_ERR : S_POLL_A;
      end
      S_POLL_A:  if (ahb.hready) w_next = S_POLL_D;
      S_POLL_D: begin
        // Only the second (hready=1) cycle of an ERROR response ends the phase
        if (ahb.hready) begin
          if (ahb.hresp || w_tmo)  w_next = S_ERR;
          else if (ahb.hrdata[0])  w_next = S_RES_A;
          else if (POLL_GAP == 0)  w_next = S_POLL_A;
          else                     w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (w_tmo)                       w_next = S_ERR;
        else if (r_gap_cnt == GAP_LAST)  w_next = S_POLL_A;
      end
      S_RES_A:   if (ahb.hready) w_next = S_RES_D;
      S_RES_D: begin
        if (ahb.hready) w_next = ahb.hresp ? S_ERR : S_NEXT;
      end
      S_NEXT:    w_next = w_last_img ? S_DONE : S_SET_IDX;
      S_DONE:    w_next = S_IDLE;
      S_ERR:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Moore bus outputs: address-phase states issue NONSEQ, all else IDLE
  always_comb begin
    w_haddr  = '0;
    w_hwrite = 1'b0;
    w_htrans = HT_IDLE;
    w_hwdata = '0;
    unique case (r_state)
      S_WR_A: begin
        w_haddr  = CTRL_ADDR;
        w_hwrite = 1'b1;
        w_htrans = HT_NONSEQ;
      end
      S_WR_D:   w_hwdata = 32'h0000_0001;
      S_POLL_A: begin
        w_haddr  = STATUS_ADDR;
        w_htrans = HT_NONSEQ;
      end
      S_RES_A: begin
        w_haddr  = RESULT_ADDR;
        w_htrans = HT_NONSEQ;
      end
      default: ;
    endcase
  end

  // Fixed fields are held at zero only while idle so reset leaves the bus all-zero
  assign w_active      = (r_state != S_IDLE);
  assign ahb.haddr     = w_haddr;
  assign ahb.hwrite    = w_hwrite;
  assign ahb.htrans    = w_htrans;
  assign ahb.hwdata    = w_hwdata;
  assign ahb.hsize     = w_active ? 3'b010  : '0;
  assign ahb.hburst    = 3'b000;
  assign ahb.hprot     = w_active ? 4'b0011 : '0;
  assign ahb.hmastlock = 1'b0;

  // State and scoring registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_pass       <= '0;
      r_fail       <= '0;
      r_last_class <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_state   <= w_next;
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 32'd1 : '0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_idx  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_pass <= '0;
            r_fail <= '0;
          end
        end
        S_RES_D: begin
          if (ahb.hready && !ahb.hresp) begin
            r_last_class <= w_rd_class;
            if (w_rd_class == w_exp_class) r_pass <= r_pass + CNT_W'(1);
            else                           r_fail <= r_fail + CNT_W'(1);
          end
        end
        S_NEXT: begin
          if (!w_last_img) r_idx <= r_idx + IDX_W'(1);
        end
        S_DONE: r_done <= 1'b1;
        S_ERR: begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign test_img_index_o = r_idx;
  assign busy_o           = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
  assign done_o           = r_done;
  assign err_o            = r_err;
  assign pass_cnt_o       = r_pass;
  assign fail_cnt_o       = r_fail;
  assign last_class_o     = r_last_class;

endmodule
